// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp
// Purpose  : Sized little-endian data-memory responder with MMIO test window
// Revision : 1.0
// ============================================================================
module dmem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic [31:0] DoneValue,
    output logic [31:0] StoreCount,
    output logic        Misaligned
);

    localparam int         c_IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_cycles;
    logic [31:0] r_rdWord;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_bad;

    logic               w_isMmio;
    logic               w_badAlign;
    logic               w_bad;
    logic               w_ramWe;
    logic               w_doneWe;
    logic [3:0]         w_mask;
    logic [31:0]        w_wdata;
    logic [31:0]        w_mmioOff;
    logic [31:0]        w_mmioRd;
    logic [c_IDX_W-1:0] w_idx;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;

    assign w_isMmio  = (DataAddr >= MMIO_BASE);
    assign w_mmioOff = DataAddr - MMIO_BASE;
    assign w_idx     = DataAddr[c_IDX_W+1:2];

    always_comb begin
        w_badAlign = 1'b0;
        case (MemSize)
            c_SZ_BYTE: w_badAlign = 1'b0;
            c_SZ_HALF: w_badAlign = DataAddr[0];
            c_SZ_WORD: w_badAlign = |DataAddr[1:0];
            default:   w_badAlign = 1'b1;
        endcase
    end

    // The MMIO window only accepts whole-word accesses, reads and writes alike.
    assign w_bad    = w_badAlign | (w_isMmio & (MemSize != c_SZ_WORD));
    assign w_ramWe  = MemWrite & ~w_isMmio & ~w_bad & ~rst;
    assign w_doneWe = MemWrite & w_isMmio & ~w_bad & (w_mmioOff == 32'd0) & ~Done;

    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = WriteData;
        case (MemSize)
            c_SZ_BYTE: begin
                w_mask  = 4'b0001 << DataAddr[1:0];
                w_wdata = {4{WriteData[7:0]}};
            end
            c_SZ_HALF: begin
                w_mask  = DataAddr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteData[15:0]}};
            end
            c_SZ_WORD: begin
                w_mask  = 4'b1111;
                w_wdata = WriteData;
            end
            default: begin
                w_mask  = 4'b0000;
                w_wdata = WriteData;
            end
        endcase
    end

    always_comb begin
        w_mmioRd = 32'd0;
        case (w_mmioOff)
            32'd4:   w_mmioRd = r_cycles;
            32'd8:   w_mmioRd = StoreCount;
            default: w_mmioRd = 32'd0;
        endcase
    end

    // RAM contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_ramWe) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles   <= 32'd0;
            r_rdWord   <= 32'd0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_bad      <= 1'b0;
            Done       <= 1'b0;
            DoneValue  <= 32'd0;
            StoreCount <= 32'd0;
            Misaligned <= 1'b0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            r_rdWord <= w_isMmio ? w_mmioRd : r_mem[w_idx];
            r_lane   <= DataAddr[1:0];
            r_size   <= MemSize;
            r_signed <= MemSigned;
            r_bad    <= w_bad;
            if (w_bad) begin
                Misaligned <= 1'b1;
            end
            if (w_ramWe) begin
                StoreCount <= StoreCount + 32'd1;
            end
            if (w_doneWe) begin
                Done      <= 1'b1;
                DoneValue <= WriteData;
            end
        end
    end

    always_comb begin
        ReadData = 32'd0;
        w_byte   = r_rdWord[{r_lane, 3'b000} +: 8];
        w_half   = r_lane[1] ? r_rdWord[31:16] : r_rdWord[15:0];
        case (r_size)
            c_SZ_BYTE: ReadData = {{24{r_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: ReadData = {{16{r_signed & w_half[15]}}, w_half};
            c_SZ_WORD: ReadData = r_rdWord;
            default:   ReadData = 32'd0;
        endcase
        if (r_bad) begin
            ReadData = 32'd0;
        end
    end

endmodule
`default_nettype wire
